// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues ROM reads, tracks them across the ROM latency
// and queues {instr, pc} for decode. Optional macro FETCH_ALIGN_CHECK_EN traps misaligned redirects.
module instr_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ROM_LATENCY = 1,
    parameter int          QDEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        halt,
    input  logic        redirect,
    input  logic [31:0] branch_target,
    output logic [31:0] rom_addr,
    output logic        rom_en,
    input  logic [31:0] rom_data,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        fetch_fault
);
    localparam int PW = $clog2(QDEPTH);
    localparam int SW = $clog2(QDEPTH + ROM_LATENCY + 1);

    typedef enum logic [1:0] {BOOT, FETCH, HALT, FAULT} state_t;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_ent_t;

    state_t                       state_q, state_d;
    logic [31:0]                  pc_q;
    logic [31:0]                  redir_pc;
    logic                         misalign;
    logic [ROM_LATENCY:1]         vld_pipe;
    logic [ROM_LATENCY:1][31:0]   pc_pipe;
    fetch_ent_t [QDEPTH-1:0]      mem;
    fetch_ent_t                   head;
    logic [PW-1:0]                wr_q, rd_q;
    logic [PW:0]                  count_q;
    logic [SW-1:0]                infl;
    logic                         credit, push, pop;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign    = redirect && (branch_target[1:0] != 2'b00);
    assign redir_pc    = branch_target;
    assign fetch_fault = (state_q == FAULT);
`else
    logic unused_tgt_bits;
    assign unused_tgt_bits = ^branch_target[1:0];
    assign misalign    = 1'b0;
    assign redir_pc    = {branch_target[31:2], 2'b00};
    assign fetch_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= BOOT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = FETCH;
            FETCH:   if (halt) state_d = HALT;
            HALT:    if (!halt) state_d = FETCH;
            FAULT:   state_d = FAULT;
            default: state_d = BOOT;
        endcase
        if (misalign) state_d = FAULT;
    end

    // Credit uses registered occupancy only; reads still in the pipe already own a FIFO slot.
    always_comb begin
        infl = '0;
        for (int i = 1; i <= ROM_LATENCY; i++) infl = infl + SW'(vld_pipe[i]);
    end

    assign credit   = (SW'(count_q) + infl) < SW'(QDEPTH);
    assign rom_en   = (state_q == FETCH) && !halt && !redirect && credit;
    assign rom_addr = pc_q;

    always_ff @(posedge clk) begin
        if (!rst_n)        pc_q <= RESET_PC;
        else if (redirect) pc_q <= redir_pc;
        else if (rom_en)   pc_q <= pc_q + 32'd4;
    end

    // A redirect kills every read in flight so late ROM data is never queued.
    always_ff @(posedge clk) begin
        if (!rst_n || redirect) begin
            vld_pipe <= '0;
            pc_pipe  <= '0;
        end else begin
            vld_pipe[1] <= rom_en;
            pc_pipe[1]  <= pc_q;
            for (int i = 2; i <= ROM_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                pc_pipe[i]  <= pc_pipe[i-1];
            end
        end
    end

    assign push        = vld_pipe[ROM_LATENCY];
    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (!rst_n || redirect) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= {rom_data, pc_pipe[ROM_LATENCY]};
    end

    assign head     = mem[rd_q];
    assign instr    = instr_valid ? head.instr : '0;
    assign instr_pc = instr_valid ? head.pc    : '0;
endmodule
